// File: rtl/ptcalc_mul_pkg.sv
// Shared types, widths and the round-robin pick helper for the pT-calc multiplier arbiter.
package ptcalc_mul_pkg;

    localparam int MUL_A_W  = 24;
    localparam int MUL_B_W  = 16;
    localparam int MUL_P_W  = 42;

    // rr_pick works on a fixed-width request vector; arbiters with up to RR_MAX requesters fit
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;

    typedef logic signed [MUL_A_W-1:0] mul_a_t;
    typedef logic signed [MUL_B_W-1:0] mul_b_t;
    typedef logic signed [MUL_P_W-1:0] mul_p_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int unsigned         n);
        rr_pick_t    r;
        int unsigned j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                j = 32'(ptr) + k;
                if (j >= n) j = j - n;
                if (!r.found && valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = RR_IDX_W'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ptcalc_mul_pipe.sv
// Fixed-latency registered signed multiplier with a matching {id, tag} sideband.
// Only the valid chain and the output stage are reset; inner data stages load on their valid.
module ptcalc_mul_pipe
    import ptcalc_mul_pkg::*;
#(
    parameter int LAT  = 2,
    parameter int SB_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  mul_a_t          in_a,
    input  mul_b_t          in_b,
    input  logic [SB_W-1:0] in_sb,
    output logic            out_valid,
    output mul_p_t          out_p,
    output logic [SB_W-1:0] out_sb
);

    localparam int MID = (LAT > 1) ? LAT - 1 : 1;

    logic [LAT-1:0]  r_v;
    mul_p_t          r_p  [MID];
    logic [SB_W-1:0] r_sb [MID];
    mul_p_t          r_p_out;
    logic [SB_W-1:0] r_sb_out;

    logic [LAT-1:0]  w_ld;
    mul_p_t          w_d_p  [LAT];
    logic [SB_W-1:0] w_d_sb [LAT];

    always_comb begin
        w_ld[0]   = in_valid;
        w_d_p[0]  = mul_p_t'(in_a) * mul_p_t'(in_b);
        w_d_sb[0] = in_sb;
        for (int i = 1; i < LAT; i++) begin
            w_ld[i]   = r_v[i-1];
            w_d_p[i]  = r_p[i-1];
            w_d_sb[i] = r_sb[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_v <= '0;
        else     r_v <= w_ld;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT - 1; i++) begin
            if (w_ld[i]) begin
                r_p[i]  <= w_d_p[i];
                r_sb[i] <= w_d_sb[i];
            end
        end
    end

    // Output stage only loads on a valid product so the result fields hold between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_out  <= '0;
            r_sb_out <= '0;
        end else if (w_ld[LAT-1]) begin
            r_p_out  <= w_d_p[LAT-1];
            r_sb_out <= w_d_sb[LAT-1];
        end
    end

    assign out_valid = r_v[LAT-1];
    assign out_p     = r_p_out;
    assign out_sb    = r_sb_out;

endmodule

// File: rtl/ptcalc_mul_arbiter.sv
// Round-robin arbiter sharing one signed 24x16 multiplier among NUM_REQ pT-calc requesters.
// Define PTCALC_MUL_ARB_STATS_EN to build per-requester saturating accept counters.
module ptcalc_mul_arbiter
    import ptcalc_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 2,
    parameter int TAG_W   = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*MUL_A_W-1:0]   req_a,
    input  logic [NUM_REQ*MUL_B_W-1:0]   req_b,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    output logic                         res_valid,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    output logic [TAG_W-1:0]             res_tag,
    output mul_p_t                       res_p
`ifdef PTCALC_MUL_ARB_STATS_EN
    ,
    input  logic                         stat_clr,
    output logic [NUM_REQ*16-1:0]        stat_grant_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int SB_W = ID_W + TAG_W;

    logic [ID_W-1:0]  r_ptr;
    rr_pick_t         w_pick;
    logic             w_acc;
    logic [ID_W-1:0]  w_gid;
    logic [ID_W-1:0]  w_ptr_nxt;
    mul_a_t           w_a;
    mul_b_t           w_b;
    logic [TAG_W-1:0] w_tag;

    always_comb begin
        w_pick    = rr_pick(RR_MAX'(req_valid), RR_IDX_W'(r_ptr), NUM_REQ);
        w_acc     = w_pick.found;
        w_gid     = w_pick.idx[ID_W-1:0];
        w_ptr_nxt = (w_pick.idx == RR_IDX_W'(NUM_REQ - 1)) ? '0
                                                            : ID_W'(w_pick.idx + 1'b1);
        req_ready = '0;
        if (w_acc) req_ready[w_gid] = 1'b1;
    end

    assign w_a   = req_a[w_gid*MUL_A_W +: MUL_A_W];
    assign w_b   = req_b[w_gid*MUL_B_W +: MUL_B_W];
    assign w_tag = req_tag[w_gid*TAG_W +: TAG_W];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)     r_ptr <= '0;
        else if (w_acc) r_ptr <= w_ptr_nxt;
    end

    ptcalc_mul_pipe #(
        .LAT  (LAT),
        .SB_W (SB_W)
    ) u_pipe (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .in_valid  (w_acc),
        .in_a      (w_a),
        .in_b      (w_b),
        .in_sb     ({w_gid, w_tag}),
        .out_valid (res_valid),
        .out_p     (res_p),
        .out_sb    ({res_id, res_tag})
    );

`ifdef PTCALC_MUL_ARB_STATS_EN
    logic [15:0] r_cnt [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        // clear takes priority over a coincident accept
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst)
                r_cnt[g] <= '0;
            else if (stat_clr)
                r_cnt[g] <= '0;
            else if (w_acc && (w_gid == ID_W'(g)) && (r_cnt[g] != 16'hFFFF))
                r_cnt[g] <= r_cnt[g] + 16'd1;
        end
        assign stat_grant_cnt[g*16 +: 16] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
// Self-checking bench for ptcalc_mul_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based round-robin / fixed-latency reference model.
module tb_ptcalc_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int LAT   = 2;
    localparam int TAG_W = 8;
    localparam int ID_W  = 2;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*24-1:0]      req_a = '0;
    logic [NREQ*16-1:0]      req_b = '0;
    logic [NREQ*TAG_W-1:0]   req_tag = '0;
    logic                    res_valid;
    logic [ID_W-1:0]         res_id;
    logic [TAG_W-1:0]        res_tag;
    logic signed [41:0]      res_p;
`ifdef PTCALC_MUL_ARB_STATS_EN
    logic                    stat_clr = 1'b0;
    logic [NREQ*16-1:0]      stat_grant_cnt;
`endif

    ptcalc_mul_arbiter #(.NUM_REQ(NREQ), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_tag        (req_tag),
        .res_valid      (res_valid),
        .res_id         (res_id),
        .res_tag        (res_tag),
        .res_p          (res_p)
`ifdef PTCALC_MUL_ARB_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_grant_cnt (stat_grant_cnt)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        int     id;
        int     tag;
        longint p;
    } exp_t;

    typedef struct {
        int     id;
        int     a;
        int     b;
        int     tag;
        longint exp_p;
    } vec_t;

    int     n_checks = 0;
    int     n_errors = 0;

    exp_t   q[$];
    int     m_ptr;
    int     m_last_id, m_last_tag;
    longint m_last_p;
    int     m_cnt [NREQ];
    int     sa [NREQ];
    int     sb [NREQ];
    int     st [NREQ];

    int     obs_ready, obs_valid, obs_id, obs_tag;
    longint obs_p;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int b, input int tag);
        logic [31:0] ua, ub, ut;
        ua = a; ub = b; ut = tag;
        req_valid[i]            = v;
        sa[i] = a; sb[i] = b; st[i] = tag & 'hFF;
        req_a[i*24 +: 24]       = ua[23:0];
        req_b[i*16 +: 16]       = ub[15:0];
        req_tag[i*TAG_W +: TAG_W] = ut[TAG_W-1:0];
    endtask

    task automatic model_clear();
        q.delete();
        m_ptr = 0;
        m_last_id = 0; m_last_tag = 0; m_last_p = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        ap_rst    = 1'b1;
        req_valid = '0;
        model_clear();
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
    endtask

    // One clock: check DUT against the model at the falling edge, then advance the model.
    task automatic step(output int g);
        exp_t e;
        @(negedge ap_clk);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[j]) g = j;
        end
        chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("res_valid", res_valid, 1);
            chk("res_id",    res_id,    e.id);
            chk("res_tag",   res_tag,   e.tag);
            chk("res_p",     res_p,     e.p);
            m_last_id = e.id; m_last_tag = e.tag; m_last_p = e.p;
        end else begin
            chk("res_valid_idle", res_valid, 0);
            chk("res_id_hold",    res_id,    m_last_id);
            chk("res_tag_hold",   res_tag,   m_last_tag);
            chk("res_p_hold",     res_p,     m_last_p);
        end
        obs_ready = req_ready; obs_valid = res_valid; obs_id = res_id;
        obs_tag = res_tag; obs_p = res_p;
        if (g >= 0) begin
            q.push_back('{cyc + LAT, g, st[g], longint'(sa[g]) * longint'(sb[g])});
            m_ptr = (g + 1) % NREQ;
            if (m_cnt[g] < 65535) m_cnt[g]++;
        end
        @(posedge ap_clk);
        #1;
    endtask

    vec_t tbl [6];

    initial begin
        int g;
        logic [23:0] ra;
        logic [15:0] rb;

        tbl[0] = '{2, -8388608, -32768, 'h5A,  64'sd274877906944};
        tbl[1] = '{0,      100,     -3, 'h11, -64'sd300};
        tbl[2] = '{1,  8388607,  32767, 'hC3,  64'sd274869485569};
        tbl[3] = '{3, -8388608,  32767, 'h7E, -64'sd274869518336};
        tbl[4] = '{1,        0,     -1, 'h00,  64'sd0};
        tbl[5] = '{3,       -1,     -1, 'hFF,  64'sd1};

        // 1. reset then idle
        do_reset();
        for (int i = 0; i < 20; i++) step(g);

        // vector table, one lone request each
        foreach (tbl[v]) begin
            set_req(tbl[v].id, 1, tbl[v].a, tbl[v].b, tbl[v].tag);
            step(g);
            chk("tbl_ready", obs_ready, 1 << tbl[v].id);
            set_req(tbl[v].id, 0, tbl[v].a, tbl[v].b, tbl[v].tag);
            step(g);
            step(g);
            chk("tbl_valid", obs_valid, 1);
            chk("tbl_id",    obs_id,    tbl[v].id);
            chk("tbl_tag",   obs_tag,   tbl[v].tag);
            chk("tbl_p",     obs_p,     tbl[v].exp_p);
        end

        // 2. lone requester 2 at full throughput
        set_req(2, 1, -8388608, -32768, 'h5A);
        for (int i = 0; i < 12; i++) begin
            step(g);
            chk("lone_ready", obs_ready, 4);
            if (i >= LAT) begin
                chk("lone_valid", obs_valid, 1);
                chk("lone_p",     obs_p,     64'sd274877906944);
                chk("lone_id",    obs_id,    2);
            end
        end
        set_req(2, 0, 0, 0, 0);
        repeat (3) step(g);

        // 3. all requesting from pointer 0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 1000 * (i + 1), -(i + 2), 'h10 + i);
        for (int i = 0; i < 12; i++) begin
            step(g);
            chk("rr_order", g, i % NREQ);
        end
        req_valid = '0;
        repeat (3) step(g);

        // 4. wrap from pointer 3 to 0
        set_req(2, 1, 5, 5, 'h22);
        step(g);
        chk("wrap_pre", g, 2);
        set_req(2, 0, 5, 5, 'h22);
        set_req(3, 1, 7, 9, 'h44);
        set_req(0, 1, 100, -3, 'h33);
        step(g);
        chk("wrap_g3", obs_ready, 8);
        set_req(3, 0, 7, 9, 'h44);
        step(g);
        chk("wrap_g0", obs_ready, 1);
        set_req(0, 0, 100, -3, 'h33);
        step(g);
        step(g);
        chk("wrap_valid", obs_valid, 1);
        chk("wrap_id",    obs_id,    0);
        chk("wrap_p",     obs_p,     -64'sd300);
        repeat (2) step(g);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    ra = 24'($urandom);
                    rb = 16'($urandom);
                    set_req(i, 1, int'($signed(ra)), int'($signed(rb)), int'($urandom_range(0, 255)));
                end
            end
            step(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        repeat (3) step(g);
`ifdef PTCALC_MUL_ARB_STATS_EN
        @(negedge ap_clk);
        for (int i = 0; i < NREQ; i++) chk("rand_stat", stat_grant_cnt[i*16 +: 16], m_cnt[i]);
        @(posedge ap_clk);
        #1;
`endif

        // 5. reset one cycle after an accept drops the product; pointer returns to 0
        set_req(1, 1, 3, 4, 'h66);
        step(g);
        chk("rst_acc", g, 1);
        ap_rst    = 1'b1;
        req_valid = '0;
        model_clear();
        @(negedge ap_clk);
        chk("rst_valid", res_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_p",     res_p,     0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        repeat (4) step(g);
        for (int i = 0; i < NREQ; i++) set_req(i, 1, i, i, i);
        step(g);
        chk("rst_ptr0", obs_ready, 1);
        req_valid = '0;
        repeat (3) step(g);

`ifdef PTCALC_MUL_ARB_STATS_EN
        // 6. saturation and clear-over-accept
        do_reset();
        set_req(1, 1, 1, 1, 1);
        repeat (70000) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("stat_sat",  stat_grant_cnt[16 +: 16], 65535);
        chk("stat_req0", stat_grant_cnt[0 +: 16],  0);
        @(posedge ap_clk);
        #1 stat_clr = 1'b1;
        @(posedge ap_clk);
        #1 stat_clr = 1'b0;
        @(negedge ap_clk);
        chk("stat_clr", stat_grant_cnt[16 +: 16], 0);
        @(negedge ap_clk);
        chk("stat_after_clr", stat_grant_cnt[16 +: 16], 1);
        req_valid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
